seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment anode scanner; successor to the fixed 4-digit anode selector.
- Sequences NUM_DIGITS anodes and supplies the digit-select index to the segment data mux.
- Adds inter-digit blanking (anti-ghosting), per-slot brightness dimming, per-digit enable with skip, and frame/digit strobes.
- Sits between the clock divider output (slow_clk) and the board anode pins.

Parameters:
- NUM_DIGITS, 4, number of anodes scanned (2..16).
- SEL_W, 2, width of sel; must equal clog2(NUM_DIGITS).
- DWELL_CYCLES, 8, slow_clk cycles of lit window per slot (≥1).
- BLANK_CYCLES, 2, slow_clk cycles with all anodes off at the start of each slot (≥1).
- BRT_W, 4, width of brightness; must hold DWELL_CYCLES.
- AN_ACTIVE_LOW, 1, 1 = anode asserted low; 0 = asserted high.

Ports:
- slow_clk  in  1  scan clock
- Reset  in  1  asynchronous, active-high reset
- digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit skipped and never lit
- brightness  in  BRT_W  lit cycles per slot; values above DWELL_CYCLES clamp to DWELL_CYCLES
- AN  out  NUM_DIGITS  registered anode drive, polarity per AN_ACTIVE_LOW
- sel  out  SEL_W  registered index of the current digit slot
- digit_strobe  out  1  one-cycle pulse in the first cycle of each slot
- frame_start  out  1  one-cycle pulse when a slot begins on a wrapped (≤ previous) index

Behaviour:
- Reset values:
  - Reset is asynchronous and active-high; clock is slow_clk.
  - sel=0; AN all inactive; digit_strobe=0; frame_start=0; state=BLANK; cnt=0; on_len=clamp(brightness).
- Slot length is BLANK_CYCLES+DWELL_CYCLES cycles.
- FSM states BLANK, ON, OFF; cnt counts cycles within the current state.
- BLANK:
  - AN all inactive for BLANK_CYCLES cycles.
  - Then go to ON if on_len>0 and digit_en[sel]=1; otherwise go to OFF.
- ON:
  - Asserts only AN[sel] for on_len cycles.
  - Then go to OFF, or end the slot if on_len=DWELL_CYCLES.
- OFF:
  - AN all inactive for the remaining DWELL_CYCLES−(lit cycles) cycles.
  - Then end the slot.
- Slot end:
  - Registered on the same edge: sel←next index, state←BLANK, digit_strobe=1.
  - on_len is resampled from brightness; brightness is sampled only at slot start, so mid-slot changes do not take effect until the next slot.
- Next index:
  - First i in sel+1, sel+2, … (mod NUM_DIGITS) with digit_en[i]=1.
  - If only sel is enabled, sel repeats.
  - If none are enabled, sel holds and AN stays inactive; slot timing keeps running.
- frame_start=1 with digit_strobe when new sel ≤ old sel (wrap, or a single enabled digit).
- The reset slot is digit 0 with no strobes.
- digit_en is sampled continuously for the lit decision:
  - Dropping digit_en[sel] during ON deasserts AN on the next edge, and the FSM moves to OFF.
  - Raising digit_en[sel] mid-slot does not light the digit until its next slot.
- Reset mid-operation forces all outputs to reset values immediately (asynchronous), with no glitch to an active anode.
- AN is always one-hot-active or all-inactive; two anodes are never active together.

Optional Feature:
- Macro SEG_SCAN_FREEZE_EN.
- Defined:
  - Adds ports freeze (in, 1) and freeze_digit (in, SEL_W).
  - While freeze=1, each slot end loads sel←freeze_digit instead of the next index.
  - frame_start is suppressed; blank and dimming behaviour are unchanged.
  - The freeze digit lights only if digit_en[freeze_digit]=1.
  - Deasserting freeze resumes normal search from the current sel at the next slot end.
- Undefined: ports absent; behaviour as above.

Decomposition:
- Shared display package/include holds:
  - FSM state encodings (BLANK=2'd0, ON=2'd1, OFF=2'd2).
  - Default NUM_DIGITS, DWELL_CYCLES, BLANK_CYCLES.
  - The clog2 constant function.
  - The anode-inactive constant per polarity.
- One sub-module, seg_next_digit: combinational rotate-priority search returning the next enabled index plus a none_enabled flag.

Test Plan (NUM_DIGITS=4, DWELL=8, BLANK=2, active-low, unless stated):
- Reset release, digit_en=1111, brightness=8 → AN=1111 ×2, 1110 ×8, 1111 ×2, 1101 ×8 …; sel 0,1,2,3,0; frame_start every 40 cycles at sel=0.
- brightness=3 → each slot: AN inactive 2, active 3, inactive 5. brightness=0 → AN=1111 always, sel still cycles. brightness=12 → clamps to 8 lit.
- digit_en=1010 → sel 1,3,1,3…; frame_start at each return to 1. digit_en=0000 → AN=1111, sel holds, digit_strobe every 10 cycles.
- Reset asserted mid-ON with AN=1011 → AN=1111 and sel=0 before the next edge. Clear digit_en[sel] mid-ON → AN inactive the next cycle.
- Brightness changed 8→2 mid-ON → current slot keeps 8 lit; next slot lit 2.
- AN_ACTIVE_LOW=0, NUM_DIGITS=8, SEL_W=3 → AN 00000001 … 10000000, one-hot each slot. With SEG_SCAN_FREEZE_EN, freeze=1, freeze_digit=2 → sel=2 from the next slot, frame_start=0.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment anode scanner.
// State encodings, default geometry and polarity helpers.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2
  } state_t;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_DWELL_CYCLES = 8;
  localparam int DEF_BLANK_CYCLES = 2;
  localparam int MAX_DIGITS       = 16;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] an_off(input bit active_low);
    return active_low ? '1 : '0;
  endfunction

endpackage

// File: rtl/seg_next_digit.sv
// Rotate-priority search for the next enabled digit after sel.
// Holds sel and flags none when no digit is enabled.
module seg_next_digit #(
  parameter int NUM_DIGITS = 4,
  parameter int SEL_W      = 2
) (
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [SEL_W-1:0]      sel,
  output logic [SEL_W-1:0]      nxt,
  output logic                  none
);

  int               idx;
  logic [SEL_W-1:0] idx_s;

  always_comb begin
    nxt   = sel;
    none  = (digit_en == '0);
    idx   = 0;
    idx_s = '0;
    // Walk from farthest to nearest so the nearest enabled digit wins.
    for (int i = NUM_DIGITS; i >= 1; i--) begin
      idx   = (int'(sel) + i) % NUM_DIGITS;
      idx_s = SEL_W'(idx);
      if (digit_en[idx_s]) nxt = idx_s;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment anode scanner with blanking, dimming and skip.
// Optional freeze-on-digit mode when SEG_SCAN_FREEZE_EN is defined.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
  parameter int SEL_W         = 2,
  parameter int DWELL_CYCLES  = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES  = DEF_BLANK_CYCLES,
  parameter int BRT_W         = 4,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                  slow_clk,
  input  logic                  Reset,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [BRT_W-1:0]      brightness,
`ifdef SEG_SCAN_FREEZE_EN
  input  logic                  freeze,
  input  logic [SEL_W-1:0]      freeze_digit,
`endif
  output logic [NUM_DIGITS-1:0] AN,
  output logic [SEL_W-1:0]      sel,
  output logic                  digit_strobe,
  output logic                  frame_start
);

  localparam int CNT_W =
    clog2_f(DWELL_CYCLES + BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST =
    CNT_W'(DWELL_CYCLES - 1);
  localparam logic [BRT_W-1:0] DWELL_B =
    BRT_W'(DWELL_CYCLES);
  localparam logic [MAX_DIGITS-1:0] AN_OFF_W =
    an_off(AN_ACTIVE_LOW);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    AN_OFF_W[NUM_DIGITS-1:0];

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [BRT_W-1:0]        on_len, on_len_d;
  logic [BRT_W-1:0]        brt_clamp;
  logic [CNT_W-1:0]        on_ext;
  logic [SEL_W-1:0]        sel_d, nxt;
  logic [NUM_DIGITS-1:0]   an_d, onehot;
  logic                    strobe_d, frame_d;
  logic                    slot_end, none;

  assign brt_clamp =
    (brightness > DWELL_B) ? DWELL_B : brightness;
  assign on_ext = CNT_W'(on_len);

  seg_next_digit #(
    .NUM_DIGITS (NUM_DIGITS),
    .SEL_W      (SEL_W)
  ) u_next (
    .digit_en (digit_en),
    .sel      (sel),
    .nxt      (nxt),
    .none     (none)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt + ONE;
    on_len_d = on_len;
    sel_d    = sel;
    strobe_d = 1'b0;
    frame_d  = 1'b0;
    slot_end = 1'b0;
    onehot   = '0;
    an_d     = AN_OFF;

    // cnt restarts at the lit window and runs across ON and OFF.
    unique case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_d = '0;
          if (on_len != '0 && digit_en[sel] && !none)
            state_d = ST_ON;
          else
            state_d = ST_OFF;
        end
      end
      ST_ON: begin
        if (cnt == DWELL_LAST)
          slot_end = 1'b1;
        else if (cnt + ONE == on_ext || !digit_en[sel])
          state_d = ST_OFF;
      end
      ST_OFF: begin
        if (cnt == DWELL_LAST) slot_end = 1'b1;
      end
      default: state_d = ST_BLANK;
    endcase

    if (slot_end) begin
      state_d  = ST_BLANK;
      cnt_d    = '0;
      on_len_d = brt_clamp;
      strobe_d = 1'b1;
`ifdef SEG_SCAN_FREEZE_EN
      if (freeze) begin
        sel_d   = freeze_digit;
        frame_d = 1'b0;
      end else begin
        sel_d   = nxt;
        frame_d = (nxt <= sel);
      end
`else
      sel_d   = nxt;
      frame_d = (nxt <= sel);
`endif
    end

    onehot = NUM_DIGITS'(1) << sel_d;
    if (state_d == ST_ON)
      an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge slow_clk or posedge Reset) begin
    if (Reset) begin
      state        <= ST_BLANK;
      cnt          <= '0;
      on_len       <= brt_clamp;
      sel          <= '0;
      AN           <= AN_OFF;
      digit_strobe <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      on_len       <= on_len_d;
      sel          <= sel_d;
      AN           <= an_d;
      digit_strobe <= strobe_d;
      frame_start  <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4-digit active-low and
// 8-digit active-high instances, slot-by-slot expected patterns.
module tb_seg_scan_ctrl;

  logic       slow_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] en0, brt0, an0;
  logic [1:0] sel0;
  logic       strb0, frm0;
  logic [7:0] en1, an1;
  logic [3:0] brt1;
  logic [2:0] sel1;
  logic       strb1, frm1;
`ifdef SEG_SCAN_FREEZE_EN
  logic       frz = 1'b0;
  logic [1:0] fd0 = 2'd0;
  logic [2:0] fd1 = 3'd0;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int slot_no = 0;

  always #5 slow_clk = ~slow_clk;

  seg_scan_ctrl dut0 (
    .slow_clk     (slow_clk),
    .Reset        (Reset),
    .digit_en     (en0),
    .brightness   (brt0),
`ifdef SEG_SCAN_FREEZE_EN
    .freeze       (frz),
    .freeze_digit (fd0),
`endif
    .AN           (an0),
    .sel          (sel0),
    .digit_strobe (strb0),
    .frame_start  (frm0)
  );

  seg_scan_ctrl #(
    .NUM_DIGITS    (8),
    .SEL_W         (3),
    .AN_ACTIVE_LOW (1'b0)
  ) dut1 (
    .slow_clk     (slow_clk),
    .Reset        (Reset),
    .digit_en     (en1),
    .brightness   (brt1),
`ifdef SEG_SCAN_FREEZE_EN
    .freeze       (frz),
    .freeze_digit (fd1),
`endif
    .AN           (an1),
    .sel          (sel1),
    .digit_strobe (strb1),
    .frame_start  (frm1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // One 10-cycle slot: 2 blank, lit cycles, then dark.
  // chg_c applies new brightness/digit_en at that cycle.
  task automatic run_slot(input int inst, input int s,
                          input int lit, input int first,
                          input int frm, input int chg_c,
                          input logic [3:0] nb,
                          input logic [3:0] ne);
    logic [31:0] exp_an, got_an, got_sel;
    logic [31:0] got_stb, got_frm;
    slot_no++;
    for (int c = 0; c < 10; c++) begin
      if (c == chg_c) begin
        brt0 = nb;
        en0  = ne;
      end
      if (inst == 0) begin
        got_an  = 32'(an0);
        got_sel = 32'(sel0);
        got_stb = 32'(strb0);
        got_frm = 32'(frm0);
        exp_an  = (c >= 2 && c < 2 + lit) ?
                  (~(32'd1 << s)) & 32'hF : 32'hF;
      end else begin
        got_an  = 32'(an1);
        got_sel = 32'(sel1);
        got_stb = 32'(strb1);
        got_frm = 32'(frm1);
        exp_an  = (c >= 2 && c < 2 + lit) ?
                  (32'd1 << s) : 32'h0;
      end
      check($sformatf("slot%0d_an_c%0d", slot_no, c),
            got_an, exp_an);
      if (c == 0) begin
        check($sformatf("slot%0d_sel", slot_no),
              got_sel, 32'(s));
        check($sformatf("slot%0d_strobe", slot_no),
              got_stb, (first != 0) ? 32'd0 : 32'd1);
        if (frm >= 0)
          check($sformatf("slot%0d_frame", slot_no),
                got_frm, 32'(frm));
      end
      if (c == 1)
        check($sformatf("slot%0d_strobe_c1", slot_no),
              got_stb, 32'd0);
      @(negedge slow_clk);
    end
  endtask

  initial begin
    en0  = 4'hF;
    brt0 = 4'd8;
    en1  = 8'hFF;
    brt1 = 4'd8;
    repeat (3) @(negedge slow_clk);
    check("rst_an0", 32'(an0), 32'hF);
    check("rst_sel0", 32'(sel0), 32'd0);
    check("rst_stb0", 32'(strb0), 32'd0);
    check("rst_frm0", 32'(frm0), 32'd0);
    check("rst_an1", 32'(an1), 32'h0);
    Reset = 1'b0;

    run_slot(0, 0, 8, 1, 0, -1, 4'd8, 4'hF);
    run_slot(0, 1, 8, 0, 0, -1, 4'd8, 4'hF);
    run_slot(0, 2, 8, 0, 0, -1, 4'd8, 4'hF);
    run_slot(0, 3, 8, 0, 0, -1, 4'd8, 4'hF);
    run_slot(0, 0, 8, 0, 1, -1, 4'd8, 4'hF);
    // brightness 8 -> 2 mid-ON
    run_slot(0, 1, 8, 0, 0, 5, 4'd2, 4'hF);
    run_slot(0, 2, 2, 0, 0, -1, 4'd2, 4'hF);
    run_slot(0, 3, 2, 0, 0, -1, 4'd2, 4'hF);
    run_slot(0, 0, 2, 0, 1, 0, 4'd3, 4'hF);
    run_slot(0, 1, 3, 0, 0, -1, 4'd3, 4'hF);
    run_slot(0, 2, 3, 0, 0, -1, 4'd3, 4'hF);
    run_slot(0, 3, 3, 0, 0, 0, 4'd0, 4'hF);
    run_slot(0, 0, 0, 0, 1, -1, 4'd0, 4'hF);
    run_slot(0, 1, 0, 0, 0, -1, 4'd0, 4'hF);
    run_slot(0, 2, 0, 0, 0, 0, 4'd12, 4'hF);
    run_slot(0, 3, 8, 0, 0, -1, 4'd12, 4'hF);
    run_slot(0, 0, 8, 0, 1, 9, 4'd12, 4'b1010);
    run_slot(0, 1, 8, 0, 0, -1, 4'd12, 4'b1010);
    run_slot(0, 3, 8, 0, 0, -1, 4'd12, 4'b1010);
    run_slot(0, 1, 8, 0, 1, -1, 4'd12, 4'b1010);
    run_slot(0, 3, 8, 0, 0, -1, 4'd12, 4'b1010);
    // drop digit_en[1] while lit
    run_slot(0, 1, 3, 0, 1, 4, 4'd12, 4'b1000);
    run_slot(0, 3, 8, 0, 0, -1, 4'd12, 4'b1000);
    run_slot(0, 3, 8, 0, 1, 9, 4'd12, 4'b0000);
    run_slot(0, 3, 0, 0, -1, -1, 4'd12, 4'b0000);
    // raise digit_en[3] after blank: stays dark this slot
    run_slot(0, 3, 0, 0, -1, 3, 4'd12, 4'b1000);
    run_slot(0, 3, 8, 0, 1, 9, 4'd12, 4'hF);
    run_slot(0, 0, 8, 0, 1, -1, 4'd12, 4'hF);
    run_slot(0, 1, 8, 0, 0, -1, 4'd12, 4'hF);

    repeat (4) @(negedge slow_clk);
    check("pre_rst_an0", 32'(an0), 32'hB);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_an0", 32'(an0), 32'hF);
    check("async_rst_sel0", 32'(sel0), 32'd0);
    check("async_rst_stb0", 32'(strb0), 32'd0);
    check("async_rst_an1", 32'(an1), 32'h0);
    @(negedge slow_clk);
    Reset = 1'b0;

    run_slot(0, 0, 8, 1, 0, -1, 4'd12, 4'hF);
    for (int s = 1; s < 8; s++)
      run_slot(1, s, 8, 0, 0, -1, 4'd12, 4'hF);
    run_slot(1, 0, 8, 0, 1, -1, 4'd12, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
